// File: rtl/axi_stripe_r_pkg.sv
// -----------------------------------------------------------------------------
// axi_stripe_r_pkg
// Shared types for the DDR striping read path.
//   - Channel count and AXI widths used by both stripe sides.
//   - stripe_desc_t: fragment descriptor {done, chan, len} exchanged between
//     the producer-side descriptor queue and the read merger.
// -----------------------------------------------------------------------------
package axi_stripe_r_pkg;

    localparam int N_DDR_CHAN      = 4;
    localparam int N_DDR_CHAN_BITS = 2;
    localparam int AXI_DATA_BITS   = 64;
    localparam int AXI_ID_BITS     = 6;
    localparam int FRAG_LEN_BITS   = 8;

    // done : this fragment closes the original burst
    // chan : DDR channel that returns the fragment
    // len  : fragment length in beats minus one
    typedef struct packed {
        logic                       done;
        logic [N_DDR_CHAN_BITS-1:0] chan;
        logic [FRAG_LEN_BITS-1:0]   len;
    } stripe_desc_t;

endpackage

// File: rtl/axi_stripe_r.sv
// -----------------------------------------------------------------------------
// axi_stripe_r
// Merges striped AXI read fragments coming back from N_DDR_CHAN DDR channels
// into one in-order read stream. Each fragment is announced by a descriptor;
// the merger forwards exactly len+1 beats from the named channel, then moves
// on to the next descriptor without an idle cycle if one is waiting.
//
// Ports
//   aclk, aresetn        clock, synchronous active-low reset
//   mux_valid_i/ready_o  descriptor handshake
//   mux_desc_i           descriptor {done, chan, len}
//   s_axi_r*_i / rready_o  per-channel read channels (slave side)
//   m_axi_r*_o / rready_i  merged read channel (master side)
//   err_o                sticky flag: channel rlast disagreed with descriptor
// -----------------------------------------------------------------------------
module axi_stripe_r
    import axi_stripe_r_pkg::*;
(
    input  logic                                      aclk,
    input  logic                                      aresetn,

    input  logic                                      mux_valid_i,
    output logic                                      mux_ready_o,
    input  stripe_desc_t                              mux_desc_i,

    input  logic [N_DDR_CHAN-1:0][AXI_DATA_BITS-1:0]  s_axi_rdata_i,
    input  logic [N_DDR_CHAN-1:0][AXI_ID_BITS-1:0]    s_axi_rid_i,
    input  logic [N_DDR_CHAN-1:0][1:0]                s_axi_rresp_i,
    input  logic [N_DDR_CHAN-1:0]                     s_axi_rlast_i,
    input  logic [N_DDR_CHAN-1:0]                     s_axi_rvalid_i,
    output logic [N_DDR_CHAN-1:0]                     s_axi_rready_o,

    output logic [AXI_DATA_BITS-1:0]                  m_axi_rdata_o,
    output logic [AXI_ID_BITS-1:0]                    m_axi_rid_o,
    output logic [1:0]                                m_axi_rresp_o,
    output logic                                      m_axi_rlast_o,
    output logic                                      m_axi_rvalid_o,
    input  logic                                      m_axi_rready_i,

    output logic                                      err_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUX  = 1'b1;

    logic [0:0]                 state_q, state_d;
    logic [N_DDR_CHAN_BITS-1:0] chan_q,  chan_d;
    logic [FRAG_LEN_BITS-1:0]   len_q,   len_d;
    logic                       done_q,  done_d;
    logic [FRAG_LEN_BITS-1:0]   cnt_q,   cnt_d;
    logic                       err_q,   err_d;

    logic in_mux;
    logic last_beat;
    logic rvalid;
    logic beat_hs;
    logic frag_end;
    logic load;

    // Datapath: zero-latency selection of the current channel.
    always_comb begin
        in_mux    = (state_q == ST_MUX);
        // cnt_q never passes len_q, so len=255 ends at cnt=255 before any wrap.
        last_beat = (cnt_q == len_q);
        rvalid    = in_mux & s_axi_rvalid_i[chan_q];
        beat_hs   = rvalid & m_axi_rready_i;
        frag_end  = beat_hs & last_beat;

        m_axi_rdata_o  = s_axi_rdata_i[chan_q];
        m_axi_rid_o    = s_axi_rid_i[chan_q];
        m_axi_rresp_o  = s_axi_rresp_i[chan_q];
        m_axi_rvalid_o = rvalid;
        // Channel rlast only marks fragment ends; burst end comes from done.
        m_axi_rlast_o  = in_mux & done_q & last_beat;

        // Non-selected channels are held off until their descriptor is current.
        s_axi_rready_o = '0;
        if (in_mux) begin
            s_axi_rready_o[chan_q] = m_axi_rready_i;
        end

        // Accepting the next descriptor on the final beat avoids a bubble.
        mux_ready_o = in_mux ? frag_end : 1'b1;
        load        = mux_valid_i & mux_ready_o;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        len_d   = len_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (load) begin
            state_d = ST_MUX;
            chan_d  = mux_desc_i.chan;
            len_d   = mux_desc_i.len;
            done_d  = mux_desc_i.done;
            cnt_d   = '0;
        end else if (frag_end) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (beat_hs) begin
            cnt_d   = cnt_q + 8'd1;
        end

        if (beat_hs && (s_axi_rlast_i[chan_q] != last_beat)) begin
            err_d = 1'b1;
        end
    end

    // Control state: reset discards any fragment in flight.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Descriptor fields are only meaningful in ST_MUX, so they carry no reset.
    always_ff @(posedge aclk) begin
        chan_q <= chan_d;
        len_q  <= len_d;
        done_q <= done_d;
    end

    assign err_o = err_q;

endmodule
